osc_startup_seq: RTL and testbench

OSC_STARTUP_SEQ -- requirements
Module: osc_startup_seq

---
 rtl/osc_startup_seq.sv | 164 ++++++++++++++++
 tb/tb_osc_startup_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_startup_seq.sv
// Oscillator start-up sequencer: counts monitored-clock edges over fixed windows,
// qualifies the clock after GOOD_REQ consecutive in-range windows and latches faults.
module osc_startup_seq #(
  parameter int unsigned WINDOW   = 1000,
  parameter int unsigned CW       = 16,
  parameter int unsigned EXP_MIN  = 18,
  parameter int unsigned EXP_MAX  = 22,
  parameter int unsigned GOOD_REQ = 4
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          mon_clk_i,
  input  logic          enable_i,
  input  logic          fault_clr_i,
  output logic          clk_ok_o,
  output logic          rst_out_n_o,
  output logic          fault_o,
  output logic [CW-1:0] last_count_o,
  output logic          cnt_valid_o
);

  localparam int unsigned   WW       = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] WIN_LOAD = WW'(WINDOW - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_MIN  = CW'(EXP_MIN);
  localparam logic [CW-1:0] CNT_MAX  = CW'(EXP_MAX);
  localparam logic [3:0]    GOOD_TGT = 4'(GOOD_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t        state_q;
  logic [2:0]    sync_q;
  logic          sync_prev_q;
  logic [WW-1:0] win_q;
  logic [CW-1:0] edge_cnt_q;
  logic [3:0]    good_run_q;
  logic          clk_ok_q;
  logic          rst_out_n_q;
  logic          fault_q;
  logic [CW-1:0] last_count_q;
  logic          cnt_valid_q;

  logic          mon_rise_d;
  logic          win_end_d;
  logic [CW-1:0] count_d;
  logic          good_d;
  logic [3:0]    good_run_inc_d;
  logic          qualify_d;

  // Edge detect, saturating window count (including an edge on the window-end cycle) and judgement.
  always_comb begin
    mon_rise_d = sync_q[2] & ~sync_prev_q;
    win_end_d  = (win_q == {WW{1'b0}});
    if (mon_rise_d && (edge_cnt_q != CNT_SAT)) begin
      count_d = edge_cnt_q + CW'(1);
    end else begin
      count_d = edge_cnt_q;
    end
    good_d         = (count_d >= CNT_MIN) && (count_d <= CNT_MAX);
    good_run_inc_d = good_run_q + 4'd1;
    qualify_d      = (good_run_inc_d >= GOOD_TGT);
  end

  // Synchronizer, window engine and sequencer state with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      sync_q       <= 3'b000;
      sync_prev_q  <= 1'b0;
      win_q        <= {WW{1'b0}};
      edge_cnt_q   <= {CW{1'b0}};
      good_run_q   <= 4'd0;
      clk_ok_q     <= 1'b0;
      rst_out_n_q  <= 1'b0;
      fault_q      <= 1'b0;
      last_count_q <= {CW{1'b0}};
      cnt_valid_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[1:0], mon_clk_i};
      sync_prev_q <= sync_q[2];
      cnt_valid_q <= 1'b0;
      if (!enable_i) begin
        state_q     <= ST_IDLE;
        win_q       <= {WW{1'b0}};
        edge_cnt_q  <= {CW{1'b0}};
        good_run_q  <= 4'd0;
        clk_ok_q    <= 1'b0;
        rst_out_n_q <= 1'b0;
        fault_q     <= 1'b0;
      end else begin
        // Windows run back to back in every active state, FAULTED included.
        if (state_q != ST_IDLE) begin
          if (win_end_d) begin
            win_q        <= WIN_LOAD;
            edge_cnt_q   <= {CW{1'b0}};
            last_count_q <= count_d;
            cnt_valid_q  <= 1'b1;
          end else begin
            win_q      <= win_q - WW'(1);
            edge_cnt_q <= count_d;
          end
        end
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_WAIT;
            win_q      <= WIN_LOAD;
            edge_cnt_q <= {CW{1'b0}};
            good_run_q <= 4'd0;
          end
          ST_WAIT: begin
            if (win_end_d) begin
              if (!good_d) begin
                good_run_q <= 4'd0;
              end else if (qualify_d) begin
                state_q     <= ST_RUN;
                good_run_q  <= 4'd0;
                clk_ok_q    <= 1'b1;
                rst_out_n_q <= 1'b1;
              end else begin
                good_run_q <= good_run_inc_d;
              end
            end
          end
          ST_RUN: begin
            if (win_end_d && !good_d) begin
              state_q     <= ST_FAULT;
              clk_ok_q    <= 1'b0;
              rst_out_n_q <= 1'b0;
              fault_q     <= 1'b1;
            end
          end
          ST_FAULT: begin
            // Clearing restarts qualification with a fresh window, overriding any window-end reload.
            if (fault_clr_i) begin
              state_q    <= ST_WAIT;
              good_run_q <= 4'd0;
              win_q      <= WIN_LOAD;
              edge_cnt_q <= {CW{1'b0}};
              fault_q    <= 1'b0;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            clk_ok_q    <= 1'b0;
            rst_out_n_q <= 1'b0;
            fault_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clk_ok_o     = clk_ok_q;
  assign rst_out_n_o  = rst_out_n_q;
  assign fault_o      = fault_q;
  assign last_count_o = last_count_q;
  assign cnt_valid_o  = cnt_valid_q;

endmodule

// File: tb/tb_osc_startup_seq.sv
// Directed bench for osc_startup_seq: per-window expectations are queued as stimulus
// is applied and retired against each CNT_VALID pulse.
module tb_osc_startup_seq;

  localparam int WINDOW   = 100;
  localparam int CW       = 4;
  localparam int EXP_MIN  = 9;
  localparam int EXP_MAX  = 11;
  localparam int GOOD_REQ = 3;

  logic          clk;
  logic          reset_n;
  logic          mon_clk;
  logic          enable;
  logic          fault_clr;
  logic          clk_ok;
  logic          rst_out_n;
  logic          fault;
  logic [CW-1:0] last_count;
  logic          cnt_valid;

  int cyc     = 0;
  int ref_cyc = 0;
  int nchk    = 0;
  int nfail   = 0;
  int mon_per = 10;
  int mon_k   = 0;

  typedef struct {
    int   lo;
    int   hi;
    logic ok;
    logic flt;
  } exp_t;
  exp_t sb[$];

  osc_startup_seq #(
    .WINDOW(WINDOW), .CW(CW), .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX), .GOOD_REQ(GOOD_REQ)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .mon_clk_i(mon_clk), .enable_i(enable),
    .fault_clr_i(fault_clr), .clk_ok_o(clk_ok), .rst_out_n_o(rst_out_n), .fault_o(fault),
    .last_count_o(last_count), .cnt_valid_o(cnt_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitored clock: square wave of mon_per cycles, or mon_k pulses packed into a 100-cycle frame.
  initial begin
    int cur_per;
    int cur_k;
    int ph;
    cur_per = -1;
    cur_k   = -1;
    ph      = 0;
    mon_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_per != cur_per || mon_k != cur_k) begin
        cur_per = mon_per;
        cur_k   = mon_k;
        ph      = 0;
      end
      if (cur_k != 0) begin
        mon_clk = (ph < 2 * cur_k) && (ph % 2 == 0);
        ph = (ph == 99) ? 0 : ph + 1;
      end else if (cur_per == 0) begin
        mon_clk = 1'b0;
      end else begin
        mon_clk = (ph < cur_per / 2);
        ph = (ph == cur_per - 1) ? 0 : ph + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    nchk++;
    assert (!$isunknown(obs) && obs >= lo && obs <= hi) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic push(input int lo, input int hi, input logic ok, input logic flt);
    sb.push_back('{lo, hi, ok, flt});
  endtask

  task automatic expect_windows(input int n);
    for (int w = 0; w < n; w++) begin
      int t;
      exp_t e;
      t = 0;
      @(negedge clk);
      while (cnt_valid !== 1'b1 && t < 150) begin
        @(negedge clk);
        t++;
      end
      if (cnt_valid !== 1'b1) begin
        chk("cnt_valid_timeout", {31'd0, cnt_valid}, 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
      end else if (sb.size() == 0) begin
        chk("unexpected_window", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk_range("last_count", {28'd0, last_count}, e.lo, e.hi);
        chk("clk_ok", {31'd0, clk_ok}, {31'd0, e.ok});
        chk("rst_out_n", {31'd0, rst_out_n}, {31'd0, e.ok});
        chk("fault", {31'd0, fault}, {31'd0, e.flt});
        chk("window_gap", cyc - ref_cyc, WINDOW);
        ref_cyc = cyc;
        @(negedge clk);
        chk("cnt_valid_one_cycle", {31'd0, cnt_valid}, 32'd0);
      end
    end
  endtask

  task automatic drop_enable();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("idle_clk_ok", {31'd0, clk_ok}, 32'd0);
    chk("idle_rst_out_n", {31'd0, rst_out_n}, 32'd0);
    chk("idle_fault", {31'd0, fault}, 32'd0);
  endtask

  task automatic raise_enable();
    @(negedge clk);
    enable  = 1'b1;
    ref_cyc = cyc + 1;
  endtask

  initial begin
    int pulses;
    reset_n   = 1'b0;
    enable    = 1'b0;
    fault_clr = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_clk_ok", {31'd0, clk_ok}, 32'd0);
    chk("rst_rst_out_n", {31'd0, rst_out_n}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_last_count", {28'd0, last_count}, 32'd0);
    chk("rst_cnt_valid", {31'd0, cnt_valid}, 32'd0);
    reset_n = 1'b1;
    pulses  = 0;
    repeat (150) begin
      @(negedge clk);
      if (cnt_valid === 1'b1) pulses++;
    end
    chk("idle_no_windows", pulses, 32'd0);

    // Period-10 clock qualifies after the third window.
    raise_enable();
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b1, 1'b0);
    push(10, 10, 1'b1, 1'b0);
    expect_windows(4);

    // FAULT_CLR while running is ignored.
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_in_run_clk_ok", {31'd0, clk_ok}, 32'd1);
    chk("clr_in_run_fault", {31'd0, fault}, 32'd0);
    push(10, 10, 1'b1, 1'b0);
    expect_windows(1);

    // Clock stops mid-window: fault latches and survives the clock returning.
    repeat (50) @(negedge clk);
    mon_per = 0;
    push(3, 7, 1'b0, 1'b1);
    push(0, 0, 1'b0, 1'b1);
    expect_windows(2);
    mon_per = 10;
    push(8, 11, 1'b0, 1'b1);
    push(10, 10, 1'b0, 1'b1);
    expect_windows(2);
    @(negedge clk);
    fault_clr = 1'b1;
    ref_cyc   = cyc + 1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_fault", {31'd0, fault}, 32'd0);
    chk("clr_clk_ok", {31'd0, clk_ok}, 32'd0);
    chk("clr_rst_out_n", {31'd0, rst_out_n}, 32'd0);
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b1, 1'b0);
    expect_windows(3);

    // One-cycle reset mid-window while running.
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_clk_ok", {31'd0, clk_ok}, 32'd0);
    chk("midrst_rst_out_n", {31'd0, rst_out_n}, 32'd0);
    chk("midrst_fault", {31'd0, fault}, 32'd0);
    chk("midrst_last_count", {28'd0, last_count}, 32'd0);
    chk("midrst_cnt_valid", {31'd0, cnt_valid}, 32'd0);
    reset_n = 1'b1;
    ref_cyc = cyc + 1;
    push(9, 11, 1'b0, 1'b0);
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b1, 1'b0);
    expect_windows(3);

    // Too-fast clock (count saturates at 15), then period 10 after a mixed window.
    drop_enable();
    mon_per = 5;
    repeat (20) @(negedge clk);
    raise_enable();
    push(15, 15, 1'b0, 1'b0);
    push(15, 15, 1'b0, 1'b0);
    expect_windows(2);
    repeat (50) @(negedge clk);
    mon_per = 10;
    push(12, 15, 1'b0, 1'b0);
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b1, 1'b0);
    expect_windows(4);

    // Dropping ENABLE after two good windows discards the good run.
    drop_enable();
    raise_enable();
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b0, 1'b0);
    expect_windows(2);
    drop_enable();
    repeat (5) @(negedge clk);
    raise_enable();
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b0, 1'b0);
    push(10, 10, 1'b1, 1'b0);
    expect_windows(3);

    // Range boundaries: 9 and 11 edges qualify, 8 and 12 do not.
    for (int i = 0; i < 4; i++) begin
      int k;
      logic good;
      k = (i == 0) ? 9 : (i == 1) ? 11 : (i == 2) ? 12 : 8;
      good = (k >= EXP_MIN) && (k <= EXP_MAX);
      drop_enable();
      mon_k = k;
      repeat (10) @(negedge clk);
      raise_enable();
      push(k, k, 1'b0, 1'b0);
      push(k, k, 1'b0, 1'b0);
      push(k, k, good, 1'b0);
      expect_windows(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
